// File: rtl/alu_writeback.sv
// ============================================================================
// Module   : alu_writeback
// Summary  : Writeback stage after the ALU. Sequences one or two register-file
//            writes per ALU result and keeps sticky divide-by-zero and
//            illegal-opcode flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_writeback #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned R0_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_out,
    input  logic [DATA_W-1:0] in_r0,
    input  logic [3:0]        in_con,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_div0,
    input  logic              flush,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              div_zero,
    output logic              illegal_op,
    output logic              busy
);

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_WR_MAIN = 2'd1;
    localparam logic [1:0] C_ST_WR_R0   = 2'd2;

    localparam logic [ADDR_W-1:0] C_R0_ADDR = ADDR_W'(R0_ADDR);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_r0;
    logic [3:0]        r_con;
    logic [ADDR_W-1:0] r_dest;
    logic              r_dual;
    logic              r_div_zero;
    logic              r_illegal;

    logic w_is_single;
    logic w_is_dual;
    logic w_is_div0;
    logic w_is_illegal;
    logic w_accept;
    logic w_accept_wr;

    // Opcode classification of the incoming result
    always_comb begin
        w_is_single  = (in_con == 4'd1) || (in_con == 4'd2);
        w_is_dual    = (in_con == 4'd4) || ((in_con == 4'd8) && !in_div0);
        w_is_div0    = (in_con == 4'd8) && in_div0;
        w_is_illegal = !(w_is_single || w_is_dual || w_is_div0);
    end

    // A held DUAL in its first write cycle still owes the R0 write
    assign in_ready    = !((r_state == C_ST_WR_MAIN) && r_dual);
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_accept_wr = w_accept && (w_is_single || w_is_dual);

    always_comb begin
        w_state_nxt = C_ST_IDLE;
        if (!flush) begin
            case (r_state)
                C_ST_IDLE:    w_state_nxt = w_accept_wr ? C_ST_WR_MAIN : C_ST_IDLE;
                C_ST_WR_MAIN: begin
                    if (r_dual)
                        w_state_nxt = C_ST_WR_R0;
                    else
                        w_state_nxt = w_accept_wr ? C_ST_WR_MAIN : C_ST_IDLE;
                end
                C_ST_WR_R0:   w_state_nxt = w_accept_wr ? C_ST_WR_MAIN : C_ST_IDLE;
                default:      w_state_nxt = C_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
            r_out   <= '0;
            r_r0    <= '0;
            r_con   <= '0;
            r_dest  <= '0;
            r_dual  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_out  <= in_out;
                r_r0   <= in_r0;
                r_con  <= in_con;
                r_dest <= in_dest;
                r_dual <= w_is_dual;
            end
        end
    end

    // Sticky flags: a new offence in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_zero <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_div_zero <= (w_accept && w_is_div0)    || (r_div_zero && !err_clr);
            r_illegal  <= (w_accept && w_is_illegal) || (r_illegal  && !err_clr);
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (r_state)
            C_ST_WR_MAIN: begin
                wr_en   = 1'b1;
                wr_addr = r_dest;
                wr_data = r_out;
            end
            C_ST_WR_R0: begin
                wr_en   = 1'b1;
                wr_addr = C_R0_ADDR;
                wr_data = r_r0;
            end
            default: ;
        endcase
    end

    assign div_zero   = r_div_zero;
    assign illegal_op = r_illegal;
    assign busy       = (r_state != C_ST_IDLE);

    // The held opcode is kept for visibility only; the class bit drives sequencing
    logic w_unused;
    assign w_unused = ^r_con;

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// ============================================================================
// Module   : tb_alu_writeback
// Summary  : Table-driven directed bench for alu_writeback plus hand-written
//            flush and asynchronous-reset sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_out;
    logic [15:0] in_r0;
    logic [3:0]  in_con;
    logic [3:0]  in_dest;
    logic        in_div0;
    logic        flush;
    logic        err_clr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        div_zero;
    logic        illegal_op;
    logic        busy;

    alu_writeback #(.DATA_W(16), .ADDR_W(4), .R0_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_out     (in_out),
        .in_r0      (in_r0),
        .in_con     (in_con),
        .in_dest    (in_dest),
        .in_div0    (in_div0),
        .flush      (flush),
        .err_clr    (err_clr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .div_zero   (div_zero),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs driven for one cycle, and the outputs expected in that cycle
    typedef struct {
        logic        vld;
        logic [3:0]  con;
        logic [15:0] o;
        logic [15:0] r;
        logic [3:0]  d;
        logic        dv0;
        logic        fl;
        logic        clr;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   ntests = 0;
    int   nfail  = 0;

    // {wr_en, wr_addr, wr_data, div_zero, illegal_op, busy, in_ready}
    function automatic logic [24:0] pack_exp(logic we, logic [3:0] wa, logic [15:0] wd,
                                             logic dz, logic il, logic rdy);
        return {we, wa, wd, dz, il, we, rdy};
    endfunction

    function automatic vec_t mk(logic vld, logic [3:0] con, logic [15:0] o, logic [15:0] r,
                                logic [3:0] d, logic dv0, logic fl, logic clr,
                                logic we, logic [3:0] wa, logic [15:0] wd,
                                logic dz, logic il, logic rdy);
        vec_t x;
        x.vld = vld; x.con = con; x.o = o; x.r = r; x.d = d;
        x.dv0 = dv0; x.fl = fl; x.clr = clr;
        x.exp = pack_exp(we, wa, wd, dz, il, rdy);
        return x;
    endfunction

    task automatic drive(logic vld, logic [3:0] con, logic [15:0] o, logic [15:0] r,
                         logic [3:0] d, logic dv0, logic fl, logic clr);
        in_valid = vld; in_con = con; in_out = o; in_r0 = r;
        in_dest = d; in_div0 = dv0; flush = fl; err_clr = clr;
    endtask

    task automatic check(string name, logic [24:0] exp);
        logic [24:0] obs;
        obs = {wr_en, wr_addr, wr_data, div_zero, illegal_op, busy, in_ready};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got en=%b addr=%h data=%h dz=%b il=%b busy=%b rdy=%b, expected en=%b addr=%h data=%h dz=%b il=%b busy=%b rdy=%b",
                     name, obs[24], obs[23:20], obs[19:4], obs[3], obs[2], obs[1], obs[0],
                     exp[24], exp[23:20], exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic idle_in();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_in();

        // cycle-by-cycle vectors (flags: dz, il)
        // single add
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(1,4'd1,16'h1234,16'h0000,4'd3,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd3,16'h1234,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // multiply: two writes, not ready during main write
        vecs.push_back(mk(1,4'd4,16'h5678,16'h0012,4'd5,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd5,16'h5678,0,0,0));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd0,16'h0012,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // back-to-back subtracts
        vecs.push_back(mk(1,4'd2,16'h00A1,16'h0000,4'd1,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(1,4'd2,16'h00A2,16'h0000,4'd2,0,0,0, 1,4'd1,16'h00A1,0,0,1));
        vecs.push_back(mk(1,4'd2,16'h00A3,16'h0000,4'd3,0,0,0, 1,4'd2,16'h00A2,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd3,16'h00A3,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // divide by zero, sticky until err_clr
        vecs.push_back(mk(1,4'd8,16'h9999,16'h8888,4'd4,1,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,1, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // illegal opcode
        vecs.push_back(mk(1,4'd7,16'h4444,16'h0000,4'd6,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,1,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,1, 0,4'd0,16'h0000,0,1,1));
        // divide with dest == R0: R0 ends with remainder
        vecs.push_back(mk(1,4'd8,16'h0003,16'h0001,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd0,16'h0003,0,0,0));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd0,16'h0001,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // set and clear in the same cycle: set wins
        vecs.push_back(mk(1,4'd8,16'h0000,16'h0000,4'd2,1,0,1, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,1, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // valid held against a stalled DUAL, accepted during the R0 write
        vecs.push_back(mk(1,4'd4,16'h0011,16'h0022,4'd6,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(1,4'd1,16'h0033,16'h0000,4'd7,0,0,0, 1,4'd6,16'h0011,0,0,0));
        vecs.push_back(mk(1,4'd1,16'h0033,16'h0000,4'd7,0,0,0, 1,4'd0,16'h0022,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 1,4'd7,16'h0033,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));
        // div0 accepted while a SINGLE write is in flight
        vecs.push_back(mk(1,4'd1,16'h0044,16'h0000,4'd8,0,0,0, 0,4'd0,16'h0000,0,0,1));
        vecs.push_back(mk(1,4'd8,16'h0055,16'h0066,4'd9,1,0,0, 1,4'd8,16'h0044,0,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,1, 0,4'd0,16'h0000,1,0,1));
        vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,4'd0,0,0,0, 0,4'd0,16'h0000,0,0,1));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack_exp(0, 4'd0, 16'h0, 0, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].con, vecs[i].o, vecs[i].r, vecs[i].d,
                  vecs[i].dv0, vecs[i].fl, vecs[i].clr);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // flush during a DUAL main write: main write still issued, R0 write cancelled
        @(negedge clk);
        drive(1'b1, 4'd4, 16'hBEEF, 16'hCAFE, 4'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("flush_main_write", pack_exp(1, 4'd9, 16'hBEEF, 0, 0, 0));
        @(negedge clk);
        idle_in();
        #1;
        check("flush_no_r0_write", pack_exp(0, 4'd0, 16'h0, 0, 0, 1));

        // flush blocks an accept in the same cycle
        @(negedge clk);
        drive(1'b1, 4'd1, 16'h7777, 16'h0, 4'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle_in();
        #1;
        check("flush_blocks_accept", pack_exp(0, 4'd0, 16'h0, 0, 0, 1));

        // asynchronous reset in the middle of a DUAL
        @(negedge clk);
        drive(1'b1, 4'd4, 16'h1111, 16'h2222, 4'd4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle_in();
        #1;
        check("pre_reset_main_write", pack_exp(1, 4'd4, 16'h1111, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", pack_exp(0, 4'd0, 16'h0, 0, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("no_write_after_reset", pack_exp(0, 4'd0, 16'h0, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
